// File: rtl/pipelined_incrementer_pkg.sv
// pipelined_incrementer_pkg: shared mode constants and occupancy width helper
package pipelined_incrementer_pkg;
   localparam int WRAP = 0;
   localparam int SAT = 1;
   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/pipelined_incrementer_pipe_stage.sv
// pipelined_incrementer_pipe_stage: one {valid, data} pipeline register that loads from its source when allowed to advance
module pipelined_incrementer_pipe_stage
   import pipelined_incrementer_pkg::*;
#(
   parameter int DataWidth = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ready_i,
   input  logic                 src_v_i,
   input  logic [DataWidth-1:0] src_d_i,
   output logic                 v_o,
   output logic [DataWidth-1:0] d_o
);
   logic                 v_q, v_d;
   logic [DataWidth-1:0] d_q, d_d;
   // take the upstream word (valid or bubble) whenever this stage may advance
   always_comb begin
      v_d = ready_i ? src_v_i : v_q;
      d_d = ready_i ? src_d_i : d_q;
   end
   // stage register; reset drops the word without waiting for a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end
   assign v_o = v_q;
   assign d_o = d_q;
endmodule

// File: rtl/pipelined_incrementer.sv
// pipelined_incrementer: Depth-stage valid/ready pipeline that adds Step to each word at the output
module pipelined_incrementer
   import pipelined_incrementer_pkg::*;
#(
   parameter int          DataWidth = 16,
   parameter int          Depth     = 2,
   parameter int unsigned Step      = 1,
   parameter int          Saturate  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DataWidth-1:0]      loadVal,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DataWidth-1:0]      resVal,
   output logic                      overflow,
   output logic [occ_w(Depth)-1:0]   occupancy
);
   localparam int OccW = occ_w(Depth);
   localparam logic [DataWidth-1:0] StepW = DataWidth'(Step);
   logic [Depth-1:0]     v, rdy, src_v;
   logic [DataWidth-1:0] d [Depth];
   logic [DataWidth-1:0] src_d [Depth];
   logic                 all_v, in_xfer, out_xfer;
   logic [DataWidth:0]   sum;
   logic [OccW-1:0]      occ_q, occ_d;
   // stage k advances unless it and every stage after it are full while the output stalls
   always_comb begin
      all_v = 1'b1;
      rdy = '0;
      for (int k = Depth - 1; k >= 0; k--) begin
         all_v = all_v & v[k];
         rdy[k] = out_ready | !all_v;
      end
   end
   // each stage is fed by its predecessor; the first stage is fed by the input port
   always_comb begin
      src_v[0] = in_valid;
      src_d[0] = loadVal;
      for (int k = 1; k < Depth; k++) begin
         src_v[k] = v[k-1];
         src_d[k] = d[k-1];
      end
   end
   for (genvar i = 0; i < Depth; i++) begin : g_stage
      pipelined_incrementer_pipe_stage #(
         .DataWidth(DataWidth)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .ready_i(rdy[i]),
         .src_v_i(src_v[i]),
         .src_d_i(src_d[i]),
         .v_o    (v[i]),
         .d_o    (d[i])
      );
   end
   assign in_ready  = rdy[0];
   assign out_valid = v[Depth-1];
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   // one extra carry bit detects overflow; saturate mode clamps to all-ones on it
   always_comb begin
      sum = {1'b0, d[Depth-1]} + {1'b0, StepW};
      overflow = sum[DataWidth];
      resVal = (Saturate == SAT && overflow) ? '1 : sum[DataWidth-1:0];
   end
   // count words held: up on accept only, down on delivery only
   always_comb begin
      occ_d = (in_xfer && !out_xfer) ? occ_q + OccW'(1) :
              (out_xfer && !in_xfer) ? occ_q - OccW'(1) : occ_q;
   end
   // occupancy register, cleared with the stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) occ_q <= '0;
      else occ_q <= occ_d;
   end
   assign occupancy = occ_q;
endmodule
